// File: rtl/window_line_buffer_pkg.sv
// window_line_buffer_pkg: shared definitions for the KxK window generator.
//   DEFAULT_DATA_W - default pixel width
//   k_legal()      - legality of a window size (odd, 3..7)
//   tap_offset()   - bit offset of tap (i,j) inside the flattened window bus
package window_line_buffer_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;

  function automatic bit k_legal(input int unsigned k);
    return (k >= 3) && (k <= 7) && ((k % 2) == 1);
  endfunction

  // i = 0 is the oldest row, j = 0 the leftmost column.
  function automatic int unsigned tap_offset(input int unsigned i, input int unsigned j,
                                             input int unsigned k, input int unsigned dw);
    return ((i * k) + j) * dw;
  endfunction

endpackage

// File: rtl/window_line_buffer_line_ram.sv
// window_line_buffer_line_ram: one line of pixel storage.
// Simple dual-port RAM, registered read, read-during-write returns old data.
//   clk                        - clock
//   wr_en / wr_addr / wr_data  - write port
//   rd_en / rd_addr            - read port (data appears one cycle later)
//   rd_data                    - registered read data
module window_line_buffer_line_ram
  import window_line_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = 640,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  (* ramstyle = "M10K" *) logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write and read in one block: a same-address read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/window_line_buffer.sv
// window_line_buffer: streaming KxK neighbourhood generator for spatial filters.
// Pixels arrive in raster order, one per in_valid cycle; the previous K-1 lines
// live in K-1 line RAMs. A complete window is presented 2 cycles after the
// pixel forming its bottom-right tap, once K-1 lines and K-1 columns have passed.
//   clk, reset (async, active-high)
//   in_valid / in_sof / in_data - pixel stream, in_sof marks (row 0, col 0)
//   out_valid  - out_window holds a complete window
//   out_window - tap (i,j) at [((i*K)+j)*DATA_W +: DATA_W], i=0 oldest row
//   out_col    - column of the newest tap; out_eol - that column is IMG_W-1
module window_line_buffer
  import window_line_buffer_pkg::*;
#(
  parameter  int unsigned DATA_W = DEFAULT_DATA_W,
  parameter  int unsigned IMG_W  = 640,
  parameter  int unsigned K      = 5,
  localparam int unsigned COL_W  = $clog2(IMG_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  output logic [K*K*DATA_W-1:0] out_window,
  output logic [COL_W-1:0]      out_col,
  output logic                  out_eol
);

  if (!k_legal(K) || (IMG_W < K)) begin : g_param_check
    $error("window_line_buffer: K must be odd in 3..7 and IMG_W must be >= K");
  end

  localparam int unsigned      LINES        = K - 1;
  localparam int unsigned      ROW_W        = $clog2(K);
  localparam int unsigned      ROT_W        = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [COL_W-1:0] LAST_COL     = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] FIRST_OK_COL = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] PRIMED_ROW   = ROW_W'(K - 1);
  localparam logic [ROT_W-1:0] LAST_ROT     = ROT_W'(LINES - 1);

  logic [COL_W-1:0]  col_q, col_d, pos_col;
  logic [ROW_W-1:0]  row_q, row_d, pos_row;
  logic [ROT_W-1:0]  rot_q, rot_d, pos_rot;
  logic              s1_acc_q, s1_acc_d, s1_ok_q, s1_ok_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [ROT_W-1:0]  s1_rot_q, s1_rot_d;
  logic [COL_W-1:0]  s1_col_q, s1_col_d;
  logic [DATA_W-1:0] ram_rd [LINES];
  logic [DATA_W-1:0] new_col [K];
  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] win_d [K][K];
  logic              out_valid_q, out_valid_d, out_eol_q, out_eol_d;
  logic [COL_W-1:0]  out_col_q, out_col_d;

  // Position of the pixel on the input this cycle; sof overrides the counters.
  always_comb begin
    pos_col = in_sof ? '0 : col_q;
    pos_row = in_sof ? '0 : row_q;
    pos_rot = in_sof ? '0 : rot_q;
  end

  // Counters and stage-1 capture. Row saturates at K-1 (enough for priming),
  // while the rotation index keeps cycling so writes stay at row mod (K-1).
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    rot_d     = rot_q;
    s1_acc_d  = in_valid;
    s1_ok_d   = s1_ok_q;
    s1_data_d = s1_data_q;
    s1_rot_d  = s1_rot_q;
    s1_col_d  = s1_col_q;
    if (in_valid) begin
      row_d = pos_row;
      rot_d = pos_rot;
      if (pos_col == LAST_COL) begin
        col_d = '0;
        row_d = (pos_row == PRIMED_ROW) ? pos_row : pos_row + ROW_W'(1);
        rot_d = (pos_rot == LAST_ROT) ? '0 : pos_rot + ROT_W'(1);
      end else begin
        col_d = pos_col + COL_W'(1);
      end
      s1_ok_d   = (pos_row == PRIMED_ROW) && (pos_col >= FIRST_OK_COL);
      s1_data_d = in_data;
      s1_rot_d  = pos_rot;
      s1_col_d  = pos_col;
    end
  end

  for (genvar l = 0; l < LINES; l++) begin : g_line
    window_line_buffer_line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .ADDR_W (COL_W)
    ) u_line_ram (
      .clk     (clk),
      .wr_en   (in_valid && (pos_rot == ROT_W'(l))),
      .wr_addr (pos_col),
      .wr_data (in_data),
      .rd_en   (in_valid),
      .rd_addr (pos_col),
      .rd_data (ram_rd[l])
    );
  end

  // The line being overwritten holds the oldest row (old-data read), so the
  // oldest-first order starts at the rotation index of the writing pixel.
  always_comb begin
    for (int unsigned i = 0; i < K; i++) new_col[i] = '0;
    for (int unsigned i = 0; i < LINES; i++) begin
      new_col[i] = ram_rd[ROT_W'((s1_rot_q + i) % LINES)];
    end
    new_col[K-1] = s1_data_q;
  end

  always_comb begin
    win_d       = win_q;
    out_valid_d = s1_acc_q & s1_ok_q;
    out_col_d   = out_col_q;
    out_eol_d   = out_eol_q;
    if (s1_acc_q) begin
      for (int unsigned i = 0; i < K; i++) begin
        for (int unsigned j = 0; j + 1 < K; j++) win_d[i][j] = win_q[i][j+1];
        win_d[i][K-1] = new_col[i];
      end
      out_col_d = s1_col_q;
      out_eol_d = s1_ok_q && (s1_col_q == LAST_COL);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      rot_q       <= '0;
      s1_acc_q    <= 1'b0;
      s1_ok_q     <= 1'b0;
      s1_data_q   <= '0;
      s1_rot_q    <= '0;
      s1_col_q    <= '0;
      win_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_eol_q   <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      rot_q       <= rot_d;
      s1_acc_q    <= s1_acc_d;
      s1_ok_q     <= s1_ok_d;
      s1_data_q   <= s1_data_d;
      s1_rot_q    <= s1_rot_d;
      s1_col_q    <= s1_col_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_eol_q   <= out_eol_d;
    end
  end

  always_comb begin
    out_window = '0;
    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j < K; j++) begin
        out_window[tap_offset(i, j, K, DATA_W) +: DATA_W] = win_q[i][j];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_eol   = out_eol_q;

endmodule

// File: doc/window_line_buffer.md
# window_line_buffer

Parametrised streaming window generator for the spatial-filter path (blur, Sobel edge detection). It accepts one pixel per valid cycle in raster order and stores the previous K-1 image lines in block RAM. Once enough lines and columns have arrived, it presents a complete K×K neighbourhood every valid cycle to the downstream kernel. It generalises the single-line 5-tap row buffer in kernel size, line width, pixel width and frame handling, and adds priming control, frame resync and valid tracking.

## Interface
- DATA_W, 8, pixel width in bits
- IMG_W, 640, pixels per line; must be ≥ K
- K, 5, window size; odd, 3..7
- COL_W, $clog2(IMG_W), column counter width (derived, not overridden)
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all counters, flags and window registers
- in_valid  in  1  pixel present this cycle; gaps allowed, no backpressure
- in_sof  in  1  qualifies in_valid; this pixel is (row 0, col 0) of a new frame
- in_data  in  DATA_W  pixel
- out_valid  out  1  out_window holds a complete window
- out_window  out  K*K*DATA_W  tap (i,j) at bits [((i*K)+j)*DATA_W +: DATA_W]; i = 0 is the oldest row, j = 0 is the leftmost column
- out_col  out  COL_W  column of the bottom-right (newest) tap
- out_eol  out  1  with out_valid: out_col == IMG_W-1

## Operation
- Accepted pixel = cycle with in_valid = 1. Cycles with in_valid = 0 change no state, except that the delay pipeline drains.
- Counters:
  - col runs 0..IMG_W-1 and wraps to 0.
  - On wrap, row increments and saturates at K-1, which is all that is needed for priming.
- in_sof on an accepted pixel forces col = 0 and row = 0 for that pixel, abandoning any partial line or frame.
  - Windows in flight for the abandoned frame still emerge from the pipeline.
  - No new window becomes valid until re-primed.
- Line storage:
  - K-1 line RAMs, each IMG_W × DATA_W, one write port and one registered read port.
  - Rotating write select: the pixel at (row r) is written to line (r mod (K-1)) at address col.
  - All lines are read at col in the same cycle. Read-during-write to the same address returns old data.
- Window:
  - K×K register array, shifted one column left per accepted pixel.
  - The new right column is the K-1 RAM outputs, reordered oldest-first by the rotation index, plus the delayed in_data.
- Valid rule: a window is valid for the pixel at (r,c) iff row ≥ K-1 and c ≥ K-1.
  - No border replication.
  - The first K-1 columns of every line and the first K-1 lines of every frame produce no output.
- Tap (i,j) = pixel (r-K+1+i, c-K+1+j).
- RAM contents are not cleared on reset or sof; priming guarantees that stale data is never marked valid.

## Timing
- Latency: out_valid, out_window, out_col and out_eol are registered and appear 2 cycles after the accepting cycle (1 cycle for RAM read, 1 for window register).
- Throughput: 1 window/cycle when in_valid is held high; out_valid mirrors in_valid delayed by 2, masked by the valid rule.
- Reset values: out_valid = 0, out_window = 0, out_col = 0, out_eol = 0, row = col = 0, rotation index = 0. Assertion mid-line discards everything in flight.
- in_sof with in_valid = 0 is ignored.
- Line wrap and in_sof on the same pixel: in_sof wins.
- Outputs hold their last value while out_valid = 0; downstream must qualify with out_valid.

## Structure
- Shared package/include holds the tap-index function (i,j → bit offset), the K legality check (odd, 3..7, elaborated as a generate-time error) and the default DATA_W.
- One sub-module, line_ram: simple dual-port, ramstyle M10K, registered read, old-data read-during-write. It is instantiated K-1 times via generate.
- Top level holds the counters, rotation index, window shift array and valid pipeline.

## Test plan
Default for directed tests: K = 3, IMG_W = 8, DATA_W = 8, pixel value = row*16 + col.
- Reset, then stream 3 full lines continuously:
  - First out_valid occurs 2 cycles after pixel (2,2).
  - Taps equal {00,01,02,10,11,12,20,21,22}.
  - out_col = 2; exactly 6 valid windows on line 2; out_eol on the window for col 7.
- Same stream with in_valid toggled 1-0-1-0: identical window sequence, each window 2 cycles after its pixel, no duplicates.
- K = 5, IMG_W = 16:
  - First valid window is at (4,4) with tap(0,0) = 0x00 and tap(4,4) = 0x44.
  - 12 windows per primed line.
- in_sof asserted mid-line 3 (col 5): no further valid windows until (2,2) of the new frame; new taps contain only new-frame values.
- Reset asserted asynchronously mid-line 4: out_valid drops immediately; re-primes exactly as from power-up.
- Line wrap: window at col 2 of line 3 has bottom row {30,31,32} and no taps from line 2's cols 6–7 in its bottom row.
